// File: rtl/regfile_dump.sv
// regfile_dump: walks every register-file entry through a dedicated read
// port and streams each value, with its index, to a debug sink over a
// valid/ready interface. It never writes the register file and never stalls
// the pipeline.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // The index counter is itself a register, so the read address is registered
  // and stays stable for the whole FETCH cycle.
  assign rf_ra = idx;

  // Dump sequencer: all outputs are registered; abort takes priority over
  // whatever the current state would otherwise do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dout_data  <= '0;
      dout_idx   <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      idx        <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          dout_data  <= rf_rd;
          dout_idx   <= idx;
          dout_last  <= (idx == LAST_IDX);
          dout_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (dout_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug readout engine that walks the 32-entry general-purpose register file through a dedicated read port and streams each register value to a debug sink over a valid/ready interface. It sits beside `regfile` in the datapath. It drives a read address into the register file's combinational read port and samples the returned data. Its output side feeds the debug/trace logic, for example a UART bridge or a testbench monitor. It does not write the register file and does not stall the pipeline.

## Interface
Parameters:
- DATA_W, 32, register width; must match the regfile data width.
- ADDR_W, 5, register index width; the dump always covers indices 0 .. 2^ADDR_W-1.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a full dump; sampled only in IDLE.
- abort  in  1  cancel the dump in progress; honoured in any non-IDLE state.
- rf_ra  out  ADDR_W  read address to the regfile read port; registered.
- rf_rd  in  DATA_W  combinational read data returned for rf_ra.
- dout_valid  out  1  dout_data, dout_idx and dout_last hold a valid word.
- dout_ready  in  1  the sink accepts the word.
- dout_data  out  DATA_W  captured register value.
- dout_idx  out  ADDR_W  register index of dout_data.
- dout_last  out  1  set with the word for index 2^ADDR_W-1.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last word completes its handshake.

## Operation
- The FSM has four states: IDLE, FETCH, SEND and DONE. A registered index counter `idx` is driven straight onto rf_ra.
- IDLE: if start=1, clear idx to 0 and go to FETCH. Otherwise stay in IDLE.
- FETCH: rf_ra=idx. At the clock edge, capture rf_rd into dout_data and idx into dout_idx, set dout_last=(idx==2^ADDR_W-1), then go to SEND.
- SEND: dout_valid=1, and dout_data, dout_idx and dout_last are held stable until the handshake.
  - On dout_valid&dout_ready with dout_last=0: idx<=idx+1, go to FETCH.
  - On dout_valid&dout_ready with dout_last=1: go to DONE.
  - Without a handshake, stay in SEND. The valid signal is never withdrawn except by abort or reset.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Abort in FETCH, SEND or DONE returns the FSM to IDLE at the next edge, clears idx and dout_valid, and does not pulse done.
  - If abort coincides with a SEND handshake, the word counts as delivered (the sink keeps it), but the dump still ends without done.
- start while busy is ignored; a pending start is not queued.
- Each word is a snapshot taken at its own FETCH edge. Regfile writes occurring during a dump appear in any register not yet fetched. The result is not an atomic image.
- Index 0 is read like any other index; the regfile returns 0 for it.
- idx never wraps past 2^ADDR_W-1 during a dump.

## Timing
- Reset (asynchronous): state=IDLE, idx=0, rf_ra=0, dout_data=0, dout_idx=0, dout_last=0, dout_valid=0, busy=0, done=0.
- start is sampled high at edge E0.
  - FETCH for index 0 during cycle E0..E1, with rf_ra=0 and busy=1 from E0.
  - dout_valid=1 from E1.
- Per word: 1 FETCH cycle plus at least 1 SEND cycle, so the maximum rate is one word per 2 clocks.
- With dout_ready tied to 1:
  - word i's handshake completes at edge E(2i+2);
  - the last handshake is at E64;
  - done=1 during E64..E65;
  - busy=0 from E65.
- dout_ready=0 inserts SEND cycles one-for-one; the data stays constant throughout.
- Abort sampled at edge Ea: dout_valid=0 and busy=0 from Ea.

## Test plan
- Preload rf[i]=32'hA5A5_0000+i with rf[0]=0 and tie dout_ready=1. Pulse start. Required response:
  - 32 words with dout_idx 0..31 and matching data;
  - dout_last only on idx 31;
  - done exactly one cycle, high after E64.
- Random dout_ready throttling, including 10-cycle stalls. Required response:
  - data, idx and last stable while valid&~ready;
  - no word dropped or duplicated;
  - the sequence is identical to the unthrottled case.
- Abort in SEND at idx 7 with dout_ready=0. Required response:
  - valid=0 and busy=0 next cycle;
  - no done;
  - a new start restarts from idx 0.
- Abort coinciding with the handshake of idx 12. Required response: word 12 is seen by the sink, then IDLE with no done.
- During the dump, write rf[20]=32'hDEAD_BEEF on a negedge before idx 20 is fetched. Required response: word 20 = 32'hDEAD_BEEF.
- Assert reset asynchronously mid-SEND. Required response:
  - all outputs 0 immediately;
  - start pulses during busy and during DONE are ignored.
